// File: rtl/four_bit_signed_multiplier.sv
// 4x4 two's-complement multiplier with a registered 8-bit product.
// A Baugh-Wooley partial-product array feeds a combinational adder; one cycle of latency.
module four_bit_signed_multiplier (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] product,
  output logic       out_valid
);

  // The inverted sign-row terms need ones added at weights 2^4 and 2^7.
  localparam logic [7:0] bw_correction = 8'h90;

  logic [3:0][7:0] rows;
  logic [7:0]      product_next;

  // Row i holds a[j]&b[i] at weight i+j; terms pairing exactly one sign bit are complemented.
  always_comb begin
    rows = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        rows[i][i+j] = (A[j] & B[i]) ^ ((i == 3) != (j == 3));
      end
    end
    product_next = rows[0] + rows[1] + rows[2] + rows[3] + bw_correction;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product   <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        product <= product_next;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_signed_multiplier.sv
// Directed and exhaustive self-checking bench for four_bit_signed_multiplier.
// Expected products are hand-computed constants or an integer signed reference.
module tb_four_bit_signed_multiplier;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] product;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  four_bit_signed_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .product   (product),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive inputs away from the active edge, then let one rising edge pass and settle.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst_n    = rst;
    in_valid = valid;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string tag, input logic [7:0] exp_product, input logic exp_valid);
    checkOutput({tag, "_product"}, product, exp_product);
    checkOutput({tag, "_valid"}, {7'b0, out_valid}, {7'b0, exp_valid});
  endtask

  typedef struct {
    string      tag;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t directed[8] = '{
    '{"p3xp2",   4'b0011, 4'b0010, 8'h06},
    '{"m6xp3",   4'b1010, 4'b0011, 8'hEE},
    '{"p7xm2",   4'b0111, 4'b1110, 8'hF2},
    '{"m4xm4",   4'b1100, 4'b1100, 8'h10},
    '{"m8xm8",   4'b1000, 4'b1000, 8'h40},
    '{"m1xp1",   4'b1111, 4'b0001, 8'hFF},
    '{"p1xm1",   4'b0001, 4'b1111, 8'hFF},
    '{"m3xp3",   4'b1101, 4'b0011, 8'hF7}
  };

  vec_t extra[4] = '{
    '{"m8xp7",   4'b1000, 4'b0111, 8'hC8},
    '{"p7xp7",   4'b0111, 4'b0111, 8'h31},
    '{"zeroxm8", 4'b0000, 4'b1000, 8'h00},
    '{"p5xzero", 4'b0101, 4'b0000, 8'h00}
  };

  initial begin
    int sa;
    int sb;
    logic [7:0] ref_p;
    logic [3:0] va;
    logic [3:0] vb;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 4'h0;
    B        = 4'h0;

    // Reset held for two cycles with a live operation that must be discarded.
    applyStimulus(1'b0, 1'b1, 4'b0111, 4'b0111);
    applyStimulus(1'b0, 1'b1, 4'b0111, 4'b0111);
    checkResult("reset", 8'h00, 1'b0);

    foreach (directed[k]) begin
      applyStimulus(1'b1, 1'b1, directed[k].a, directed[k].b);
      checkResult(directed[k].tag, directed[k].p, 1'b1);
    end
    foreach (extra[k]) begin
      applyStimulus(1'b1, 1'b1, extra[k].a, extra[k].b);
      checkResult(extra[k].tag, extra[k].p, 1'b1);
    end

    // Back-to-back stream: out_valid stays high across consecutive results.
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd2);
    checkResult("stream0", 8'h06, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'd6, 4'd5);
    checkResult("stream1", 8'h1E, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'b1110, 4'b1110);
    checkResult("stream2", 8'h04, 1'b1);

    // Hold: changing operands without in_valid must not disturb the product.
    applyStimulus(1'b1, 1'b1, 4'd1, 4'd3);
    checkResult("hold_load", 8'h03, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 4'(k + 5), 4'(k + 9));
      checkResult($sformatf("hold%0d", k), 8'h03, 1'b0);
    end

    // Reset mid-stream discards the operation in flight.
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd2);
    checkResult("pre_abort", 8'h06, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0110, 4'b0101);
    checkResult("abort", 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0110, 4'b0101);
    checkResult("post_abort", 8'h1E, 1'b1);

    // Every operand pair against an integer signed reference.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        va = 4'(ia);
        vb = 4'(ib);
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        ref_p = 8'(sa * sb);
        applyStimulus(1'b1, 1'b1, va, vb);
        checkOutput($sformatf("exh_%0d_%0d", sa, sb), product, ref_p);
      end
    end
    checkOutput("exh_valid", {7'b0, out_valid}, 8'h01);

    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    checkOutput("idle_valid", {7'b0, out_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_signed_multiplier.md
FOUR_BIT_SIGNED_MULTIPLIER -- requirements
Module: four_bit_signed_multiplier

Interface
REQ-001 The block SHALL have no parameters: operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port in_valid, input, 1 bit: when high, A and B are sampled at the next rising clk edge.
REQ-006 Port A, input, 4 bits: multiplicand, two's complement, range -8..+7.
REQ-007 Port B, input, 4 bits: multiplier, two's complement, range -8..+7.
REQ-008 Port product, output, 8 bits: registered signed product A*B, two's complement.
REQ-009 Port out_valid, output, 1 bit: high for one cycle when product holds a newly computed result.

Function
REQ-010 The block SHALL compute product = signed(A) * signed(B) as the exact 8-bit two's-complement result for all 256 operand pairs; no overflow, saturation or truncation.
REQ-011 The product SHALL be formed by a Baugh-Wooley (or equivalent signed) partial-product array with explicit sign handling, not by an unsigned multiply of the raw bit patterns.
REQ-012 Partial-product reduction and the final addition SHALL be combinational; the result SHALL be captured in the product register.
REQ-013 Latency SHALL be exactly 1 cycle: with in_valid high at rising edge N, product and out_valid SHALL reflect that operand pair immediately after edge N.
REQ-014 At an edge where in_valid is low, product SHALL hold its previous value and out_valid SHALL be low.
REQ-015 Back-to-back operation SHALL be supported: in_valid high on consecutive edges SHALL yield one new result per cycle, with out_valid high continuously.
REQ-016 Boundary results SHALL be exact:
- -8 * -8 = +64 (8'h40)
- -8 * +7 = -56 (8'hC8)
- +7 * +7 = +49 (8'h31)
- any operand 0 gives 8'h00
REQ-017 The output SHALL have no combinational path from A, B or in_valid to product or out_valid.

Reset
REQ-018 When rst_n is low at a rising clk edge, product SHALL become 8'h00 and out_valid SHALL become 0, regardless of in_valid.
REQ-019 Reset SHALL take priority over a simultaneous in_valid; an operation presented in a reset cycle SHALL be discarded.
REQ-020 Asserting reset mid-stream SHALL abort the result in flight; the first valid operands after rst_n returns high SHALL produce a correct result 1 cycle later.
REQ-021 Outputs SHALL be undefined only before the first reset edge; the bench SHALL apply reset for at least 2 cycles at start.

Verification
REQ-022 Directed sign cases, each with in_valid=1 for one cycle -> next-cycle product and out_valid=1:
- A=4'b0011, B=4'b0010 -> 8'h06
- A=4'b1010, B=4'b0011 -> 8'hEE (-18)
- A=4'b0111, B=4'b1110 -> 8'hF2 (-14)
- A=4'b1100, B=4'b1100 -> 8'h10 (+16)
REQ-023 Extremes: A=4'b1000, B=4'b1000 -> 8'h40; A=4'b1111, B=4'b0001 -> 8'hFF; A=4'b0001, B=4'b1111 -> 8'hFF; A=4'b1101, B=4'b0011 -> 8'hF7.
REQ-024 Streaming: apply 3*2, then 6*5, then -2*-2 on consecutive cycles -> 8'h06, 8'h1E, 8'h04 on consecutive cycles, with out_valid high throughout.
REQ-025 Hold: compute 1*3 = 8'h03, then change A and B with in_valid=0 for 3 cycles -> product stays 8'h03 and out_valid=0.
REQ-026 Reset mid-stream: rst_n=0 with in_valid=1, A=4'b0110, B=4'b0101 -> product 8'h00 and out_valid 0; then release reset -> the next valid 6*5 gives 8'h1E.
REQ-027 Exhaustive: all 256 (A,B) pairs -> each product equals the signed reference product.
